// File: rtl/y86_seq_controller.sv
// Multi-cycle stage sequencer for the sequential Y86-64 core.
// Steps each instruction through F/D/E/M/W/PC phases and freezes on halt or fault.
module y86_seq_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       icode,
    input  logic             imem_error,
    input  logic             mem_ready,
    input  logic             dmem_error,
    output logic             f_en,
    output logic             d_en,
    output logic             e_en,
    output logic             m_en,
    output logic             w_en,
    output logic             pc_en,
    output logic             mem_req,
    output logic             mem_wr,
    output logic [3:0]       icode_q,
    output logic [2:0]       stat,
    output logic             halted,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        MEMORY,
        WRITEBACK,
        PCUPD,
        HALT
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    state_t state;
    logic   needs_mem;
    logic   needs_wb_direct;
    logic   mem_writes;

    // Instruction classes, all derived from the icode captured in FETCH
    assign needs_mem       = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    assign needs_wb_direct = icode_q inside {4'h2, 4'h3, 4'h6};
    assign mem_writes      = icode_q inside {4'h4, 4'h8, 4'hA};

    assign f_en    = (state == FETCH);
    assign d_en    = (state == DECODE);
    assign e_en    = (state == EXECUTE);
    assign m_en    = (state == MEMORY);
    assign w_en    = (state == WRITEBACK);
    assign pc_en   = (state == PCUPD);
    assign mem_req = (state == MEMORY);
    assign mem_wr  = (state == MEMORY) && mem_writes;
    assign halted  = (state == HALT);
    assign busy    = (state != IDLE) && (state != HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            icode_q   <= 4'h0;
            stat      <= STAT_AOK;
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (busy) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            unique case (state)
                IDLE: begin
                    if (run) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    icode_q <= icode;
                    // Address error outranks halt, which outranks an invalid code
                    if (imem_error) begin
                        state <= HALT;
                        stat  <= STAT_ADR;
                    end else if (icode == 4'h0) begin
                        state <= HALT;
                        stat  <= STAT_HLT;
                    end else if (icode > 4'hB) begin
                        state <= HALT;
                        stat  <= STAT_INS;
                    end else begin
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    state <= EXECUTE;
                end
                EXECUTE: begin
                    if (needs_mem) begin
                        state <= MEMORY;
                    end else if (needs_wb_direct) begin
                        state <= WRITEBACK;
                    end else begin
                        state <= PCUPD;
                    end
                end
                MEMORY: begin
                    if (mem_ready) begin
                        if (dmem_error) begin
                            state <= HALT;
                            stat  <= STAT_ADR;
                        end else if (icode_q == 4'h4) begin
                            state <= PCUPD;
                        end else begin
                            state <= WRITEBACK;
                        end
                    end
                end
                WRITEBACK: begin
                    state <= PCUPD;
                end
                PCUPD: begin
                    instr_cnt <= instr_cnt + CNT_W'(1);
                    state     <= run ? FETCH : IDLE;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
